// File: rtl/viterbi_pkg.sv
// Shared types and constants for the BER test sequencer that drives the
// conv_encoder -> viterbi_dec chain.
package viterbi_pkg;

    typedef enum logic [2:0] {IDLE, SEND, TAIL, DRAIN, DONE} bert_state_t;

    localparam logic [6:0] PRBS7_SEED = 7'h7F;
    // x^7 + x^6 + 1: feedback is the XOR of state bits 6 and 5
    localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;
    localparam int         AXIS_W     = 8;

    // One LFSR step; the transmitted bit is the MSB of the current state
    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], ^(s & PRBS7_TAPS)};
    endfunction

endpackage

// File: rtl/viterbi_bert_ctrl_if.sv
// Control, status and both AXI-stream legs of the BER sequencer.
// master = the sequencer, slave = the surrounding system / bench.
interface viterbi_bert_ctrl_if;
    import viterbi_pkg::*;

    logic              start;
    logic              inj_err;
    logic              enc_tvalid;
    logic              enc_tready;
    logic [AXIS_W-1:0] enc_tdata;
    logic              dec_tvalid;
    logic              dec_tready;
    logic [AXIS_W-1:0] dec_tdata;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              overrun;
    logic [31:0]       bit_count;
    logic [31:0]       err_count;

    modport master (
        input  start, inj_err, enc_tready, dec_tvalid, dec_tdata,
        output enc_tvalid, enc_tdata, dec_tready, busy, done, timeout, overrun,
               bit_count, err_count
    );

    modport slave (
        output start, inj_err, enc_tready, dec_tvalid, dec_tdata,
        input  enc_tvalid, enc_tdata, dec_tready, busy, done, timeout, overrun,
               bit_count, err_count
    );

endinterface

// File: rtl/ref_bit_fifo.sv
// Synchronous 1-bit FIFO holding transmitted reference bits until the
// decoder returns them. DEPTH must be a power of two, >= 2.
module ref_bit_fifo #(
    parameter int DEPTH = 128
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees the slot, so push at full is allowed then
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointers with an extra wrap bit to tell full from empty
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/viterbi_bert_ctrl.sv
// BER test sequencer: sends a PRBS-7 frame plus zero tail into the encoder,
// keeps each sent bit in a reference FIFO and scores the decoder output.
module viterbi_bert_ctrl
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 1024,  // payload bits, >= 1
    parameter int TAIL_LEN  = 6,     // zero flush bits, >= 1
    parameter int REF_DEPTH = 128,   // power of 2, larger than decoder latency
    parameter int TIMEOUT   = 4096   // DRAIN clocks allowed without a decoder beat
) (
    input  logic                clk,
    input  logic                reset,
    viterbi_bert_ctrl_if.master bus
);
    localparam logic [31:0] TOTAL     = 32'(FRAME_LEN + TAIL_LEN);
    localparam logic [31:0] LAST_PAY  = 32'(FRAME_LEN - 1);
    localparam logic [31:0] LAST_TAIL = 32'(TAIL_LEN - 1);
    localparam logic [31:0] IDLE_MAX  = 32'(TIMEOUT);

    bert_state_t state;
    logic [6:0]  prbs;
    logic [31:0] beat_cnt;
    logic [31:0] idle_cnt;
    logic [31:0] bit_count;
    logic [31:0] err_count;
    logic        active;
    logic        done;
    logic        timeout;
    logic        overrun;
    logic        enc_tvalid;
    logic        ref_bit;
    logic        tx_bit;
    logic        enc_fire;
    logic        dec_fire;
    logic        fifo_clr;
    logic        fifo_pop;
    logic        fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic        unused_dec_hi;

    // Valid only falls on a push (which needs acceptance) filling the FIFO, so
    // a pending beat is never withdrawn. inj_err must be held while pending.
    assign enc_tvalid = (state == SEND || state == TAIL) && !fifo_full;
    assign ref_bit    = (state == SEND) ? prbs[6] : 1'b0;
    assign tx_bit     = ref_bit ^ (bus.inj_err && state == SEND);
    assign enc_fire   = enc_tvalid && bus.enc_tready;
    assign dec_fire   = bus.dec_tvalid && active;
    assign fifo_pop   = dec_fire && !fifo_empty;
    assign fifo_clr   = (state == IDLE) && bus.start;

    assign bus.enc_tvalid = enc_tvalid;
    assign bus.enc_tdata  = {{(AXIS_W-1){1'b0}}, tx_bit};
    assign bus.dec_tready = active;
    assign bus.busy       = active;
    assign bus.done       = done;
    assign bus.timeout    = timeout;
    assign bus.overrun    = overrun;
    assign bus.bit_count  = bit_count;
    assign bus.err_count  = err_count;
    assign unused_dec_hi  = ^bus.dec_tdata[AXIS_W-1:1];

    ref_bit_fifo #(.DEPTH(REF_DEPTH)) u_ref_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (fifo_clr),
        .push  (enc_fire),
        .din   (ref_bit),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Frame sequencing FSM with PRBS, beat and DRAIN idle counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            prbs     <= PRBS7_SEED;
            beat_cnt <= '0;
            idle_cnt <= '0;
            active   <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state    <= SEND;
                    active   <= 1'b1;
                    prbs     <= PRBS7_SEED;
                    beat_cnt <= '0;
                    idle_cnt <= '0;
                    timeout  <= 1'b0;
                end
                SEND: if (enc_fire) begin
                    prbs <= prbs7_next(prbs);
                    if (beat_cnt == LAST_PAY) begin
                        state    <= TAIL;
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + 32'd1;
                    end
                end
                TAIL: if (enc_fire) begin
                    if (beat_cnt == LAST_TAIL) begin
                        state    <= DRAIN;
                        beat_cnt <= '0;
                        idle_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + 32'd1;
                    end
                end
                DRAIN: begin
                    if (fifo_empty && bit_count == TOTAL) begin
                        state  <= DONE;
                        active <= 1'b0;
                        done   <= 1'b1;
                    end else if (idle_cnt == IDLE_MAX) begin
                        state   <= DONE;
                        active  <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                    if (dec_fire)
                        idle_cnt <= '0;
                    else if (idle_cnt != IDLE_MAX)
                        idle_cnt <= idle_cnt + 32'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Comparator: score each decoder beat against the oldest reference bit
    always_ff @(posedge clk) begin
        if (reset || fifo_clr) begin
            bit_count <= '0;
            err_count <= '0;
            overrun   <= 1'b0;
        end else if (dec_fire) begin
            if (fifo_empty) begin
                overrun <= 1'b1;
            end else begin
                bit_count <= bit_count + 32'd1;
                if (bus.dec_tdata[0] != fifo_dout && err_count != 32'hFFFF_FFFF)
                    err_count <= err_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_viterbi_bert_ctrl.sv
// Bench for viterbi_bert_ctrl: ideal delayed loopback from encoder input to
// decoder output, table of frame scenarios plus reset/idle corner sequences.
module tb_viterbi_bert_ctrl;
    import viterbi_pkg::*;

    localparam int FL = 16, TL = 6, TOTAL = FL + TL, DEPTH = 8, TMO = 200;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    viterbi_bert_ctrl_if bus();

    viterbi_bert_ctrl #(
        .FRAME_LEN(FL), .TAIL_LEN(TL), .REF_DEPTH(DEPTH), .TIMEOUT(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [FL-1:0] inj;       // payload beats sent inverted
        int            rdy_mode;  // 0 always ready, 1 toggle, 2 random
        int            delay;     // loopback delay in clocks
        int            deliver;   // decoder beats returned from the loopback
        int            extra;     // spurious beats once the loopback is drained
        bit            restart;   // pulse start again while busy
        int            exp_bits;
        int            exp_errs;
        bit            exp_tmo;
        bit            exp_ovr;
    } vec_t;

    typedef struct { int t; logic b; } beat_t;

    int   tests = 0, fails = 0;
    logic ref_bits [TOTAL];
    vec_t vecs [6];
    vec_t cv;
    beat_t dq [$];
    int   cyc = 0, acc_cnt, pops, deliver_left, extra_left, done_cyc, last_pop_cyc;
    int   sb_bits, sb_errs;
    bit   sb_ovr, frame_active, start_req, prev_stall;
    logic [7:0] prev_tdata, first8;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic init_model(input vec_t v);
        cv = v; acc_cnt = 0; pops = 0; sb_bits = 0; sb_errs = 0; sb_ovr = 0;
        dq.delete(); deliver_left = v.deliver; extra_left = v.extra;
        done_cyc = -1; last_pop_cyc = -1; prev_stall = 0; first8 = '0; frame_active = 0;
    endtask

    // One clock: drive inputs at negedge, then check and update the model
    task automatic cycle();
        int occ;
        bit from_q;
        @(negedge clk);
        cyc++;
        bus.start = start_req;
        start_req = 1'b0;
        case (cv.rdy_mode)
            0:       bus.enc_tready = 1'b1;
            1:       bus.enc_tready = 1'(cyc % 2);
            default: bus.enc_tready = ($urandom_range(0, 2) != 0);
        endcase
        bus.inj_err = (acc_cnt < FL) ? cv.inj[acc_cnt] : 1'b0;
        from_q = 0;
        bus.dec_tvalid = 1'b0;
        bus.dec_tdata = '0;
        if (deliver_left > 0 && dq.size() > 0 && dq[0].t <= cyc) begin
            from_q = 1;
            bus.dec_tvalid = 1'b1;
            bus.dec_tdata = {7'b0, dq[0].b};
        end else if (extra_left > 0 && deliver_left == 0 && frame_active) begin
            bus.dec_tvalid = 1'b1;
        end
        #1;
        occ = acc_cnt - pops;
        if (frame_active && bus.done) begin
            done_cyc = cyc;
            frame_active = 0;
        end
        check("enc_tvalid", bus.enc_tvalid, frame_active && acc_cnt < TOTAL && occ < DEPTH);
        check("dec_tready", bus.dec_tready, frame_active);
        check("busy", bus.busy, frame_active);
        if (prev_stall) begin
            check("stall_valid", bus.enc_tvalid, 1);
            check("stall_data", bus.enc_tdata, prev_tdata);
        end
        prev_stall = bus.enc_tvalid && !bus.enc_tready;
        prev_tdata = bus.enc_tdata;
        if (bus.enc_tvalid && bus.enc_tready && acc_cnt < TOTAL) begin
            check("enc_tdata", bus.enc_tdata, {7'b0, ref_bits[acc_cnt] ^ bus.inj_err});
            if (acc_cnt < 8) first8 = {first8[6:0], bus.enc_tdata[0]};
            dq.push_back('{t: cyc + cv.delay, b: bus.enc_tdata[0]});
            acc_cnt++;
        end
        if (bus.dec_tvalid && bus.dec_tready) begin
            if (from_q) begin
                dq.delete(0);
                deliver_left--;
            end else begin
                extra_left--;
            end
            if (occ > 0) begin
                sb_bits++;
                if (bus.dec_tdata[0] != ref_bits[pops]) sb_errs++;
                pops++;
                last_pop_cyc = cyc;
            end else begin
                sb_ovr = 1;
            end
        end
        if (bus.start && !frame_active) frame_active = 1;
    endtask

    task automatic run_vec(input vec_t v, input bit chk_first);
        init_model(v);
        start_req = 1'b1;
        for (int i = 0; i < 4000 && done_cyc < 0; i++) begin
            if (v.restart && i == 12) start_req = 1'b1;
            cycle();
        end
        check("done_seen", done_cyc >= 0, 1);
        if (done_cyc >= 0) begin
            check("bit_count", bus.bit_count, v.exp_bits);
            check("bit_count_model", bus.bit_count, sb_bits);
            check("err_count", bus.err_count, v.exp_errs);
            check("err_count_model", bus.err_count, sb_errs);
            check("timeout", bus.timeout, v.exp_tmo);
            check("overrun", bus.overrun, v.exp_ovr);
            check("overrun_model", bus.overrun, sb_ovr);
            check("done_latency", done_cyc - last_pop_cyc, v.exp_tmo ? TMO + 2 : 2);
            if (chk_first) check("first8_tdata", first8, 8'hFE);
            cycle();
            check("done_pulse", bus.done, 0);
            check("busy_after", bus.busy, 0);
        end
    endtask

    initial begin
        logic [FL-1:0] rmask;
        // Reference PRBS-7 output sequence: s[n+7] = s[n] ^ s[n+1], seeded all-ones
        for (int n = 0; n < TOTAL; n++) begin
            if (n < 7)       ref_bits[n] = 1'b1;
            else if (n < FL) ref_bits[n] = ref_bits[n-7] ^ ref_bits[n-6];
            else             ref_bits[n] = 1'b0;
        end
        rmask = FL'($urandom);
        vecs[0] = '{16'h0000, 0, 40, 22, 0, 0, 22, 0, 0, 0};
        vecs[1] = '{16'h0208, 0, 40, 22, 0, 0, 22, 2, 0, 0};
        vecs[2] = '{16'h0000, 1, 60, 22, 0, 0, 22, 0, 0, 0};
        vecs[3] = '{16'h0000, 0, 40, 20, 0, 0, 20, 0, 1, 0};
        vecs[4] = '{16'h0000, 0, 40, 22, 1, 0, 22, 0, 0, 1};
        vecs[5] = '{rmask, 2, int'($urandom_range(20, 70)), 22, 0, 0, 22, $countones(rmask), 0, 0};
        init_model(vecs[0]);

        // Reset with start held: reset wins, everything idle
        bus.start = 1'b1; bus.inj_err = 1'b0; bus.enc_tready = 1'b1;
        bus.dec_tvalid = 1'b0; bus.dec_tdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_enc_tvalid", bus.enc_tvalid, 0);
        check("rst_dec_tready", bus.dec_tready, 0);
        check("rst_flags", {bus.timeout, bus.overrun}, 0);
        check("rst_counts", {bus.bit_count, bus.err_count}, 0);
        check("rst_enc_tdata", bus.enc_tdata, 0);

        // Spurious decoder beats while idle are refused
        @(negedge clk);
        reset = 1'b0; bus.start = 1'b0;
        bus.dec_tvalid = 1'b1; bus.dec_tdata = 8'h01;
        repeat (3) begin
            @(negedge clk); #1;
            check("idle_dec_tready", bus.dec_tready, 0);
            check("idle_overrun", bus.overrun, 0);
            check("idle_bits", bus.bit_count, 0);
        end
        bus.dec_tvalid = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i == 0);

        // Reset mid-SEND after some bits have been scored
        init_model(vecs[0]);
        start_req = 1'b1;
        for (int i = 0; i < 46; i++) cycle();
        check("pre_reset_bits_nz", bus.bit_count != 0, 1);
        @(negedge clk);
        reset = 1'b1; bus.dec_tvalid = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_counts", {bus.bit_count, bus.err_count}, 0);
        check("mid_rst_enc_tvalid", bus.enc_tvalid, 0);
        check("mid_rst_dec_tready", bus.dec_tready, 0);

        // Fresh frame reproduces the first scenario; a start while busy is ignored
        cv = vecs[0];
        cv.restart = 1;
        run_vec(cv, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
        $fatal(1);
    end

endmodule
